// File: rtl/lock_pkg.sv
// Shared types and helpers for the keypad lock controller.
package lock_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StEntry,
        StPgPc,
        StPgNew1,
        StPgNew2,
        StLockout
    } state_e;

    localparam logic [1:0] ModeIdle    = 2'b00;
    localparam logic [1:0] ModeEntry   = 2'b01;
    localparam logic [1:0] ModeProg    = 2'b10;
    localparam logic [1:0] ModeLockout = 2'b11;

    localparam int unsigned MaxCodeW = 256;

    // Bit mask covering the first len digits of a packed code.
    function automatic logic [MaxCodeW-1:0] len_mask(input int unsigned len,
                                                     input int unsigned digit_w);
        logic [MaxCodeW-1:0] m;
        for (int unsigned i = 0; i < MaxCodeW; i++) begin
            m[i] = (i < len * digit_w);
        end
        return m;
    endfunction

endpackage

// File: rtl/lock_controller_code_buffer.sv
// Digit capture buffer with overflow tracking and length-aware compare.
module code_buffer
    import lock_pkg::*;
#(
    parameter int unsigned DIGIT_W = 4,
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clr_i,
    input  logic                       wr_i,
    input  logic [DIGIT_W-1:0]         digit_i,
    input  logic [MAX_LEN*DIGIT_W-1:0] ref_i,
    input  logic [LEN_W-1:0]           ref_len_i,
    output logic [MAX_LEN*DIGIT_W-1:0] buf_o,
    output logic [LEN_W-1:0]           cnt_o,
    output logic                       ovf_o,
    output logic                       match_o
);

    localparam int unsigned CodeW = MAX_LEN * DIGIT_W;

    logic [CodeW-1:0]    buf_q, buf_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic [MaxCodeW-1:0] mask_full;

    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (wr_i) begin
            if (cnt_q == LEN_W'(MAX_LEN)) begin
                ovf_d = 1'b1;
            end else begin
                buf_d[cnt_q*DIGIT_W +: DIGIT_W] = digit_i;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Digits beyond cnt are stale and must not influence the result.
    assign mask_full = len_mask(32'(cnt_q), DIGIT_W);
    assign match_o   = !ovf_q && (cnt_q == ref_len_i) &&
                       (((buf_q ^ ref_i) & mask_full[CodeW-1:0]) == '0);
    assign buf_o     = buf_q;
    assign cnt_o     = cnt_q;
    assign ovf_o     = ovf_q;

endmodule

// File: rtl/lock_controller.sv
// Keypad lock FSM: lock/unlock, reprogramming, failure lockout and inactivity timeout.
module lock_controller
    import lock_pkg::*;
#(
    parameter int unsigned DIGIT_W = 4,
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = 4,
    parameter logic [MAX_LEN*DIGIT_W-1:0] DEFAULT_UC = {8{4'd6}},
    parameter int unsigned DEFAULT_UC_LEN = 6,
    parameter logic [MAX_LEN*DIGIT_W-1:0] PC = 32'h00214445,
    parameter int unsigned PC_LEN      = 6,
    parameter int unsigned KEY_ENTER   = 9,
    parameter int unsigned KEY_PROG    = 8,
    parameter int unsigned KEY_CANCEL  = 7,
    parameter int unsigned MAX_FAILS   = 3,
    parameter int unsigned LOCKOUT_CYC = 1000,
    parameter int unsigned TIMEOUT_CYC = 5000
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [DIGIT_W-1:0] BUTTON,
    input  logic               BPRESS,
    output logic               LOCKED,
    output logic               BUSY,
    output logic [1:0]         MODE,
    output logic               OK,
    output logic               PROG_DONE,
    output logic               FAIL,
    output logic               LOCKOUT,
    output logic [LEN_W-1:0]   FAIL_CNT
);

    localparam int unsigned CodeW    = MAX_LEN * DIGIT_W;
    localparam int unsigned TimerMax = (LOCKOUT_CYC > TIMEOUT_CYC) ? LOCKOUT_CYC : TIMEOUT_CYC;
    localparam int unsigned TimerW   = $clog2(TimerMax + 1);

    state_e              state_q, state_d;
    logic                locked_q, locked_d;
    logic                ok_q, ok_d, prog_done_q, prog_done_d, fail_q, fail_d;
    logic [LEN_W-1:0]    fail_cnt_q, fail_cnt_d, fail_cnt_inc;
    logic [CodeW-1:0]    uc_q, uc_d, newcode_q, newcode_d;
    logic [LEN_W-1:0]    uc_len_q, uc_len_d, newlen_q, newlen_d;
    logic [TimerW-1:0]   timer_q, timer_d;

    logic                buf_clr, buf_wr, buf_ovf, buf_match, seq_fail;
    logic                is_enter, is_prog, is_cancel, is_digit;
    logic [CodeW-1:0]    buf_code, ref_code;
    logic [LEN_W-1:0]    buf_cnt, ref_len;

    assign is_enter  = (BUTTON == DIGIT_W'(KEY_ENTER));
    assign is_prog   = (BUTTON == DIGIT_W'(KEY_PROG));
    assign is_cancel = (BUTTON == DIGIT_W'(KEY_CANCEL));
    assign is_digit  = !(is_enter || is_prog || is_cancel);

    always_comb begin
        ref_code = uc_q;
        ref_len  = uc_len_q;
        if (state_q == StPgPc) begin
            ref_code = PC;
            ref_len  = LEN_W'(PC_LEN);
        end else if (state_q == StPgNew2) begin
            ref_code = newcode_q;
            ref_len  = newlen_q;
        end
    end

    code_buffer #(
        .DIGIT_W (DIGIT_W),
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_code_buffer (
        .clk_i     (CLK),
        .rst_i     (RST),
        .clr_i     (buf_clr),
        .wr_i      (buf_wr),
        .digit_i   (BUTTON),
        .ref_i     (ref_code),
        .ref_len_i (ref_len),
        .buf_o     (buf_code),
        .cnt_o     (buf_cnt),
        .ovf_o     (buf_ovf),
        .match_o   (buf_match)
    );

    assign fail_cnt_inc = (fail_cnt_q < LEN_W'(MAX_FAILS)) ? fail_cnt_q + 1'b1 : fail_cnt_q;

    always_comb begin
        state_d     = state_q;
        locked_d    = locked_q;
        fail_cnt_d  = fail_cnt_q;
        uc_d        = uc_q;
        uc_len_d    = uc_len_q;
        newcode_d   = newcode_q;
        newlen_d    = newlen_q;
        timer_d     = timer_q + 1'b1;
        ok_d        = 1'b0;
        prog_done_d = 1'b0;
        fail_d      = 1'b0;
        buf_clr     = 1'b0;
        buf_wr      = 1'b0;
        seq_fail    = 1'b0;

        unique case (state_q)
            StIdle: begin
                timer_d = '0;
                if (BPRESS && (is_enter || is_prog)) begin
                    state_d = is_enter ? StEntry : StPgPc;
                    buf_clr = 1'b1;
                end
            end
            StEntry, StPgPc, StPgNew1, StPgNew2: begin
                // Expiry takes priority; a press in the same cycle is dropped.
                if (timer_q == TimerW'(TIMEOUT_CYC - 1)) begin
                    seq_fail = 1'b1;
                end else if (BPRESS) begin
                    timer_d = '0;
                    if (is_cancel) begin
                        seq_fail = 1'b1;
                    end else if (is_digit) begin
                        buf_wr = 1'b1;
                    end else if (state_q == StEntry) begin
                        if (is_enter && buf_match) begin
                            locked_d   = !locked_q;
                            ok_d       = 1'b1;
                            fail_cnt_d = '0;
                            state_d    = StIdle;
                        end else begin
                            seq_fail = 1'b1;
                        end
                    end else if (is_enter) begin
                        seq_fail = 1'b1;
                    end else if (state_q == StPgPc) begin
                        if (buf_match) begin
                            state_d = StPgNew1;
                            buf_clr = 1'b1;
                        end else begin
                            seq_fail = 1'b1;
                        end
                    end else if (state_q == StPgNew1) begin
                        if (buf_cnt == '0 || buf_ovf) begin
                            seq_fail = 1'b1;
                        end else begin
                            newcode_d = buf_code;
                            newlen_d  = buf_cnt;
                            state_d   = StPgNew2;
                            buf_clr   = 1'b1;
                        end
                    end else if (buf_match) begin
                        uc_d        = newcode_q;
                        uc_len_d    = newlen_q;
                        prog_done_d = 1'b1;
                        fail_cnt_d  = '0;
                        state_d     = StIdle;
                    end else begin
                        seq_fail = 1'b1;
                    end
                end
            end
            StLockout: begin
                if (timer_q == TimerW'(LOCKOUT_CYC - 1)) begin
                    fail_cnt_d = '0;
                    timer_d    = '0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (seq_fail) begin
            fail_d     = 1'b1;
            fail_cnt_d = fail_cnt_inc;
            timer_d    = '0;
            state_d    = (fail_cnt_inc == LEN_W'(MAX_FAILS)) ? StLockout : StIdle;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= StIdle;
            locked_q    <= 1'b1;
            fail_cnt_q  <= '0;
            uc_q        <= DEFAULT_UC;
            uc_len_q    <= LEN_W'(DEFAULT_UC_LEN);
            newcode_q   <= '0;
            newlen_q    <= '0;
            timer_q     <= '0;
            ok_q        <= 1'b0;
            prog_done_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            locked_q    <= locked_d;
            fail_cnt_q  <= fail_cnt_d;
            uc_q        <= uc_d;
            uc_len_q    <= uc_len_d;
            newcode_q   <= newcode_d;
            newlen_q    <= newlen_d;
            timer_q     <= timer_d;
            ok_q        <= ok_d;
            prog_done_q <= prog_done_d;
            fail_q      <= fail_d;
        end
    end

    always_comb begin
        MODE = ModeIdle;
        unique case (state_q)
            StEntry:                      MODE = ModeEntry;
            StPgPc, StPgNew1, StPgNew2:   MODE = ModeProg;
            StLockout:                    MODE = ModeLockout;
            default:                      MODE = ModeIdle;
        endcase
    end

    assign BUSY      = (state_q != StIdle) && (state_q != StLockout);
    assign LOCKOUT   = (state_q == StLockout);
    assign LOCKED    = locked_q;
    assign OK        = ok_q;
    assign PROG_DONE = prog_done_q;
    assign FAIL      = fail_q;
    assign FAIL_CNT  = fail_cnt_q;

endmodule

// File: tb/tb_lock_controller.sv
// Directed bench for lock_controller: vector table plus timeout, lockout and reset sequences.
module tb_lock_controller;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] BUTTON = 4'd0;
    logic       BPRESS = 1'b0;
    logic       LOCKED, BUSY, OK, PROG_DONE, FAIL, LOCKOUT;
    logic [1:0] MODE;
    logic [3:0] FAIL_CNT;

    int checks = 0;
    int errors = 0;

    lock_controller dut (
        .CLK       (CLK),
        .RST       (RST),
        .BUTTON    (BUTTON),
        .BPRESS    (BPRESS),
        .LOCKED    (LOCKED),
        .BUSY      (BUSY),
        .MODE      (MODE),
        .OK        (OK),
        .PROG_DONE (PROG_DONE),
        .FAIL      (FAIL),
        .LOCKOUT   (LOCKOUT),
        .FAIL_CNT  (FAIL_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [95:0] keys;   // first key in the most significant used nibble
        int          n;
        logic        ok;
        logic        fl;
        logic        pd;
        logic        locked;
        logic [3:0]  fc;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge CLK);
        BUTTON = k;
        BPRESS = 1'b1;
        @(negedge CLK);
        BPRESS = 1'b0;
    endtask

    task automatic press_seq(input logic [95:0] keys, input int n);
        for (int i = 0; i < n; i++) begin
            press(keys[(n-1-i)*4 +: 4]);
        end
    endtask

    function automatic vec_t mk(input logic [95:0] keys, input int n, input logic ok,
                                input logic fl, input logic pd, input logic locked,
                                input logic [3:0] fc);
        vec_t v;
        v.keys = keys; v.n = n; v.ok = ok; v.fl = fl; v.pd = pd; v.locked = locked; v.fc = fc;
        return v;
    endfunction

    initial begin
        int hi;
        //                  keys                      n   ok fl pd  L  fc
        tbl[0]  = mk(96'h96666669,               8,  1, 0, 0, 0, 0);
        tbl[1]  = mk(96'h96666669,               8,  1, 0, 0, 1, 0);
        tbl[2]  = mk(96'h9666669,                7,  0, 1, 0, 1, 1);
        tbl[3]  = mk(96'h9666669,                7,  0, 1, 0, 1, 2);
        tbl[4]  = mk(96'h96666669,               8,  1, 0, 0, 0, 0);
        tbl[5]  = mk(96'h8544412812381238,       16, 0, 0, 1, 0, 0);
        tbl[6]  = mk(96'h91239,                  5,  1, 0, 0, 1, 0);
        tbl[7]  = mk(96'h96666669,               8,  0, 1, 0, 1, 1);
        tbl[8]  = mk(96'h8544412812381248,       16, 0, 1, 0, 1, 2);
        tbl[9]  = mk(96'h91239,                  5,  1, 0, 0, 0, 0);
        tbl[10] = mk(96'h854441281111111118,     18, 0, 1, 0, 0, 1);
        tbl[11] = mk(96'h967,                    3,  0, 1, 0, 0, 2);
        tbl[12] = mk(96'h91239,                  5,  1, 0, 0, 1, 0);
        tbl[13] = mk(96'h918,                    3,  0, 1, 0, 1, 1);
        tbl[14] = mk(96'h89,                     2,  0, 1, 0, 1, 2);
        tbl[15] = mk(96'h91239,                  5,  1, 0, 0, 0, 0);
        tbl[16] = mk(96'h5391239,                7,  1, 0, 0, 1, 0);
        tbl[17] = mk(96'h85444128448448,         14, 0, 0, 1, 1, 0);
        tbl[18] = mk(96'h9449,                   4,  1, 0, 0, 0, 0);

        repeat (3) @(negedge CLK);
        chk("rst_locked", LOCKED, 1);
        chk("rst_mode", MODE, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_pulses", {OK, PROG_DONE, FAIL, LOCKOUT}, 0);
        chk("rst_fail_cnt", FAIL_CNT, 0);
        RST = 1'b0;

        for (int r = 0; r < 19; r++) begin
            press_seq(tbl[r].keys, tbl[r].n);
            chk($sformatf("row%0d_ok", r), OK, tbl[r].ok);
            chk($sformatf("row%0d_fail", r), FAIL, tbl[r].fl);
            chk($sformatf("row%0d_prog_done", r), PROG_DONE, tbl[r].pd);
            chk($sformatf("row%0d_locked", r), LOCKED, tbl[r].locked);
            chk($sformatf("row%0d_fail_cnt", r), FAIL_CNT, tbl[r].fc);
            chk($sformatf("row%0d_mode", r), MODE, 0);
        end

        // Press one cycle before expiry keeps the sequence alive (UC is 4,4).
        press(4'd9);
        press(4'd4);
        repeat (4997) @(negedge CLK);
        press(4'd4);
        chk("near_timeout_fail", FAIL, 0);
        chk("near_timeout_mode", MODE, 1);
        press(4'd9);
        chk("near_timeout_ok", OK, 1);
        chk("near_timeout_locked", LOCKED, 1);

        press(4'd9);
        press(4'd4);
        repeat (4999) @(negedge CLK);
        chk("pre_timeout_fail", FAIL, 0);
        chk("pre_timeout_mode", MODE, 1);
        @(negedge CLK);
        chk("timeout_fail", FAIL, 1);
        chk("timeout_fail_cnt", FAIL_CNT, 1);
        chk("timeout_mode", MODE, 0);

        press(4'd9);
        press(4'd4);
        repeat (4998) @(negedge CLK);
        press(4'd4);
        chk("coincident_fail", FAIL, 1);
        chk("coincident_fail_cnt", FAIL_CNT, 2);
        chk("coincident_mode", MODE, 0);

        press_seq(96'h949, 3);
        chk("lockout_fail", FAIL, 1);
        chk("lockout_fail_cnt", FAIL_CNT, 3);
        chk("lockout_high", LOCKOUT, 1);
        chk("lockout_mode", MODE, 3);
        chk("lockout_busy", BUSY, 0);
        hi = 1;
        press_seq(96'h9449, 4);
        hi += 8;
        chk("lockout_ignore_ok", OK, 0);
        chk("lockout_ignore_mode", MODE, 3);
        chk("lockout_ignore_locked", LOCKED, 1);
        while (LOCKOUT && hi < 2000) begin
            @(negedge CLK);
            if (LOCKOUT) hi++;
        end
        chk("lockout_cycles", hi, 1000);
        chk("post_lockout_fail_cnt", FAIL_CNT, 0);
        chk("post_lockout_mode", MODE, 0);
        press_seq(96'h9449, 4);
        chk("post_lockout_ok", OK, 1);
        chk("post_lockout_locked", LOCKED, 0);

        // Reset in the middle of the second new-code entry.
        press_seq(96'h854441281281, 12);
        chk("pg_new2_mode", MODE, 2);
        chk("pg_new2_busy", BUSY, 1);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("mid_rst_locked", LOCKED, 1);
        chk("mid_rst_mode", MODE, 0);
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_pulses", {OK, PROG_DONE, FAIL, LOCKOUT}, 0);
        chk("mid_rst_fail_cnt", FAIL_CNT, 0);
        @(negedge CLK);
        RST = 1'b0;
        press_seq(96'h9449, 4);
        chk("old_code_rejected", FAIL, 1);
        press_seq(96'h96666669, 8);
        chk("default_uc_ok", OK, 1);
        chk("default_uc_locked", LOCKED, 0);
        chk("default_uc_fail_cnt", FAIL_CNT, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
